// File: rtl/lane_pkg.sv
// Shared playfield geometry, tile codes and per-lane motion constants used by the
// lane engine, the frog controller and the renderer.
package lane_pkg;

  localparam int unsigned NumLanes      = 10;
  localparam int unsigned RowGoal       = 0;
  localparam int unsigned RowRiverFirst = 1;
  localparam int unsigned RowRiverLast  = 5;
  localparam int unsigned RowMedian     = 6;
  localparam int unsigned RowRoadFirst  = 7;
  localparam int unsigned RowRoadLast   = 11;
  localparam int unsigned RowLast       = 14;

  typedef enum logic [3:0] {
    TileSafe  = 4'd0,
    TileRoad  = 4'd1,
    TileWater = 4'd2,
    TileLog   = 4'd3,
    TileGoal  = 4'd4,
    TileCar   = 4'd5
  } tile_e;

  typedef enum logic {
    DirLeft  = 1'b0,
    DirRight = 1'b1
  } dir_e;

  // Lane index 0-4 maps to river rows 1-5, lane index 5-9 to road rows 7-11.
  localparam int unsigned LanePeriod [NumLanes] = '{1, 2, 3, 4, 2, 1, 2, 3, 4, 1};

  localparam dir_e LaneDir [NumLanes] = '{
    DirLeft, DirRight, DirLeft, DirRight, DirLeft,
    DirRight, DirLeft, DirRight, DirLeft, DirRight
  };

  // Wide enough for any column count a 6-bit column coordinate can address.
  localparam logic [63:0] LaneInit [NumLanes] = '{
    64'h0001, 64'h0070, 64'h0E1C, 64'h3C03, 64'h01C7,
    64'h1111, 64'h0618, 64'h2082, 64'h0C30, 64'h0909
  };

  function automatic logic row_is_river(logic [5:0] row);
    return (32'(row) >= RowRiverFirst) && (32'(row) <= RowRiverLast);
  endfunction

  function automatic logic row_is_road(logic [5:0] row);
    return (32'(row) >= RowRoadFirst) && (32'(row) <= RowRoadLast);
  endfunction

  // Only meaningful for river and road rows.
  function automatic logic [3:0] row_to_lane(logic [5:0] row);
    return (32'(row) <= RowRiverLast) ? 4'(row - 6'd1) : 4'(row - 6'd2);
  endfunction

endpackage

// File: rtl/lane_shifter.sv
// One hazard lane: occupancy pattern that rotates one column every c_PERIOD base ticks.
module lane_shifter
  import lane_pkg::*;
#(
  parameter int unsigned         c_GRID_W = 14,
  parameter int unsigned         c_PERIOD = 1,
  parameter dir_e                c_DIR    = DirLeft,
  parameter logic [c_GRID_W-1:0] c_INIT   = '0
) (
  input  logic                i_Clk,
  input  logic                i_Rst_N,
  input  logic                i_Tick,
  output logic [c_GRID_W-1:0] o_Pattern,
  output logic                o_Step
);

  logic [c_GRID_W-1:0] pattern_q, pattern_d;
  logic [1:0]          step_cnt_q, step_cnt_d;
  logic                step;

  always_comb begin
    step       = i_Tick && (step_cnt_q == 2'(c_PERIOD - 1));
    step_cnt_d = step_cnt_q;
    pattern_d  = pattern_q;
    if (step) begin
      step_cnt_d = '0;
      // Left: new[c] = old[c+1]; right: new[c] = old[c-1]; both wrap the end bit.
      pattern_d  = (c_DIR == DirLeft) ? {pattern_q[0], pattern_q[c_GRID_W-1:1]}
                                      : {pattern_q[c_GRID_W-2:0], pattern_q[c_GRID_W-1]};
    end else if (i_Tick) begin
      step_cnt_d = step_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      pattern_q  <= c_INIT;
      step_cnt_q <= '0;
    end else begin
      pattern_q  <= pattern_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign o_Pattern = pattern_q;
  assign o_Step    = step;

endmodule

// File: rtl/hazard_lane_engine.sv
// Ten moving hazard lanes (logs and cars) with frog status and renderer tile lookup.
module hazard_lane_engine
  import lane_pkg::*;
#(
  parameter int unsigned c_TICK_DIV = 6250000,
  parameter int unsigned c_GRID_W   = 14
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_Game_Active,
  input  logic [5:0] i_Frogger_X,
  input  logic [5:0] i_Frogger_Y,
  input  logic [5:0] i_Col_Count_Div,
  input  logic [5:0] i_Row_Count_Div,
  output logic       o_On_Log,
  output logic       o_Collided,
  output logic [3:0] o_Cell_Type,
  output logic       o_Frog_Carry
);

  localparam int unsigned TickW = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
  localparam logic [c_GRID_W-1:0] ColOne = {{(c_GRID_W-1){1'b0}}, 1'b1};

  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic                base_tick;
  logic [c_GRID_W-1:0] lane_pat [NumLanes];
  logic [NumLanes-1:0] lane_step;

  logic       frog_valid, frog_river, frog_road, frog_bit;
  logic [3:0] frog_lane;
  logic       qry_valid, qry_river, qry_road, qry_bit;
  logic [3:0] qry_lane;

  logic       on_log_q, collided_q, carry_q;
  tile_e      cell_q, cell_d;

  // Counter holds its phase while the game is paused.
  always_comb begin
    base_tick  = i_Game_Active && (tick_cnt_q == TickW'(c_TICK_DIV - 1));
    tick_cnt_d = tick_cnt_q;
    if (base_tick) begin
      tick_cnt_d = '0;
    end else if (i_Game_Active) begin
      tick_cnt_d = tick_cnt_q + TickW'(1);
    end
  end

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    lane_shifter #(
      .c_GRID_W (c_GRID_W),
      .c_PERIOD (LanePeriod[l]),
      .c_DIR    (LaneDir[l]),
      .c_INIT   (LaneInit[l][c_GRID_W-1:0])
    ) u_lane (
      .i_Clk     (i_Clk),
      .i_Rst_N   (i_Rst_N),
      .i_Tick    (base_tick),
      .o_Pattern (lane_pat[l]),
      .o_Step    (lane_step[l])
    );
  end

  // Lookups use the current (pre-step) patterns.
  always_comb begin
    frog_valid = (32'(i_Frogger_X) < c_GRID_W) && (32'(i_Frogger_Y) <= RowLast);
    frog_river = row_is_river(i_Frogger_Y);
    frog_road  = row_is_road(i_Frogger_Y);
    frog_lane  = (frog_river || frog_road) ? row_to_lane(i_Frogger_Y) : '0;
    frog_bit   = |(lane_pat[frog_lane] & (ColOne << i_Frogger_X));

    qry_valid  = (32'(i_Col_Count_Div) < c_GRID_W) && (32'(i_Row_Count_Div) <= RowLast);
    qry_river  = row_is_river(i_Row_Count_Div);
    qry_road   = row_is_road(i_Row_Count_Div);
    qry_lane   = (qry_river || qry_road) ? row_to_lane(i_Row_Count_Div) : '0;
    qry_bit    = |(lane_pat[qry_lane] & (ColOne << i_Col_Count_Div));

    cell_d = TileSafe;
    if (qry_valid) begin
      if (32'(i_Row_Count_Div) == RowGoal) begin
        cell_d = TileGoal;
      end else if (qry_river) begin
        cell_d = qry_bit ? TileLog : TileWater;
      end else if (qry_road) begin
        cell_d = qry_bit ? TileCar : TileRoad;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      tick_cnt_q <= '0;
      on_log_q   <= 1'b0;
      collided_q <= 1'b0;
      carry_q    <= 1'b0;
      cell_q     <= TileSafe;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      on_log_q   <= frog_valid && frog_river && frog_bit;
      collided_q <= frog_valid && frog_road && frog_bit;
      carry_q    <= frog_river && lane_step[frog_lane] && on_log_q;
      cell_q     <= cell_d;
    end
  end

  assign o_On_Log     = on_log_q;
  assign o_Collided   = collided_q;
  assign o_Frog_Carry = carry_q;
  assign o_Cell_Type  = cell_q;

endmodule

// File: tb/tb_hazard_lane_engine.sv
// Self-checking bench: directed scenarios plus randomized play against a reference model
// that derives every lane pattern from the total count of active cycles.
module tb_hazard_lane_engine;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned GridW   = 14;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game_active;
  logic [5:0] frog_x, frog_y, qry_col, qry_row;
  logic       on_log, collided, frog_carry;
  logic [3:0] cell_type;

  always #5 clk = ~clk;

  hazard_lane_engine #(
    .c_TICK_DIV (TickDiv),
    .c_GRID_W   (GridW)
  ) dut (
    .i_Clk           (clk),
    .i_Rst_N         (rst_n),
    .i_Game_Active   (game_active),
    .i_Frogger_X     (frog_x),
    .i_Frogger_Y     (frog_y),
    .i_Col_Count_Div (qry_col),
    .i_Row_Count_Div (qry_row),
    .o_On_Log        (on_log),
    .o_Collided      (collided),
    .o_Cell_Type     (cell_type),
    .o_Frog_Carry    (frog_carry)
  );

  // Reference lane table indexed by playfield row.
  int unsigned ref_period [16];
  bit          ref_left   [16];
  logic [13:0] ref_init   [16];

  int unsigned act_cnt;
  bit          exp_on, exp_coll, exp_carry;
  logic [3:0]  exp_cell;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int unsigned lane_steps(int row, int unsigned cnt);
    return (cnt / TickDiv) / ref_period[row];
  endfunction

  function automatic bit ref_bit(int row, int col, int unsigned cnt);
    int unsigned s, idx;
    s = lane_steps(row, cnt) % GridW;
    if (ref_left[row]) idx = (col + s) % GridW;
    else               idx = (col + GridW - s) % GridW;
    return ref_init[row][idx];
  endfunction

  function automatic logic [3:0] ref_cell(int col, int row, int unsigned cnt);
    if (col >= GridW || row > 14) return 4'd0;
    if (row == 0) return 4'd4;
    if (row >= 1 && row <= 5) return ref_bit(row, col, cnt) ? 4'd3 : 4'd2;
    if (row >= 7 && row <= 11) return ref_bit(row, col, cnt) ? 4'd5 : 4'd1;
    return 4'd0;
  endfunction

  // Drive one cycle of inputs, advance one clock, compare all outputs with the model.
  task automatic step_cycle(input bit act, input int fx, input int fy, input int qc,
                            input int qr);
    bit          nb_on, nb_coll, nb_carry, river, in_rng;
    logic [3:0]  nb_cell;
    int unsigned nxt;
    game_active = act;
    frog_x  = 6'(fx);
    frog_y  = 6'(fy);
    qry_col = 6'(qc);
    qry_row = 6'(qr);
    nxt      = act ? act_cnt + 1 : act_cnt;
    in_rng   = (fx < GridW) && (fy <= 14);
    river    = (fy >= 1) && (fy <= 5);
    nb_on    = in_rng && river && ref_bit(fy, fx, act_cnt);
    nb_coll  = in_rng && (fy >= 7) && (fy <= 11) && ref_bit(fy, fx, act_cnt);
    nb_carry = river && exp_on && (lane_steps(fy, nxt) != lane_steps(fy, act_cnt));
    nb_cell  = ref_cell(qc, qr, act_cnt);
    @(posedge clk);
    act_cnt   = nxt;
    exp_on    = nb_on;
    exp_coll  = nb_coll;
    exp_carry = nb_carry;
    exp_cell  = nb_cell;
    #1;
    check_eq("on_log", {31'b0, on_log}, {31'b0, exp_on});
    check_eq("collided", {31'b0, collided}, {31'b0, exp_coll});
    check_eq("frog_carry", {31'b0, frog_carry}, {31'b0, exp_carry});
    check_eq("cell_type", {28'b0, cell_type}, {28'b0, exp_cell});
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check_eq("rst_on_log", {31'b0, on_log}, 32'd0);
    check_eq("rst_collided", {31'b0, collided}, 32'd0);
    check_eq("rst_carry", {31'b0, frog_carry}, 32'd0);
    check_eq("rst_cell", {28'b0, cell_type}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    act_cnt   = 0;
    exp_on    = 1'b0;
    exp_coll  = 1'b0;
    exp_carry = 1'b0;
    exp_cell  = 4'd0;
  endtask

  initial begin
    int fx, fy, qc, qr;
    for (int r = 0; r < 16; r++) begin
      ref_period[r] = 1; ref_left[r] = 1'b0; ref_init[r] = '0;
    end
    ref_period[1]  = 1; ref_left[1]  = 1'b1; ref_init[1]  = 14'h0001;
    ref_period[2]  = 2; ref_left[2]  = 1'b0; ref_init[2]  = 14'h0070;
    ref_period[3]  = 3; ref_left[3]  = 1'b1; ref_init[3]  = 14'h0E1C;
    ref_period[4]  = 4; ref_left[4]  = 1'b0; ref_init[4]  = 14'h3C03;
    ref_period[5]  = 2; ref_left[5]  = 1'b1; ref_init[5]  = 14'h01C7;
    ref_period[7]  = 1; ref_left[7]  = 1'b0; ref_init[7]  = 14'h1111;
    ref_period[8]  = 2; ref_left[8]  = 1'b1; ref_init[8]  = 14'h0618;
    ref_period[9]  = 3; ref_left[9]  = 1'b0; ref_init[9]  = 14'h2082;
    ref_period[10] = 4; ref_left[10] = 1'b1; ref_init[10] = 14'h0C30;
    ref_period[11] = 1; ref_left[11] = 1'b0; ref_init[11] = 14'h0909;

    rst_n = 1'b0; game_active = 1'b0;
    frog_x = '0; frog_y = 6'd13; qry_col = '0; qry_row = '0;
    act_cnt = 0;

    // Reset state, first tick on cycle 4, left wrap of lane 1.
    do_reset(2);
    repeat (3) step_cycle(1, 0, 13, 0, 1);
    check_eq("init_lane1_c0", {28'b0, cell_type}, 32'd3);
    step_cycle(1, 0, 13, 13, 1);
    check_eq("pre_step_lane1_c13", {28'b0, cell_type}, 32'd2);
    step_cycle(1, 0, 13, 13, 1);
    check_eq("wrap_lane1_c13", {28'b0, cell_type}, 32'd3);
    step_cycle(1, 0, 13, 0, 1);
    check_eq("wrap_lane1_c0", {28'b0, cell_type}, 32'd2);

    // Collision one cycle after landing on a car, cleared after moving to safety.
    do_reset(1);
    step_cycle(1, 3, 8, 20, 3);
    check_eq("coll_set", {31'b0, collided}, 32'd1);
    check_eq("query_oor", {28'b0, cell_type}, 32'd0);
    step_cycle(1, 3, 12, 0, 0);
    check_eq("coll_clr", {31'b0, collided}, 32'd0);
    check_eq("goal_cell", {28'b0, cell_type}, 32'd4);

    // Log carry: lane 2 steps on the second tick (cycle 8).
    do_reset(1);
    repeat (7) step_cycle(1, 5, 2, 5, 2);
    check_eq("carry_before", {31'b0, frog_carry}, 32'd0);
    check_eq("on_log_before", {31'b0, on_log}, 32'd1);
    step_cycle(1, 5, 2, 5, 2);
    check_eq("carry_pulse", {31'b0, frog_carry}, 32'd1);
    step_cycle(1, 5, 2, 5, 2);
    check_eq("carry_single", {31'b0, frog_carry}, 32'd0);
    check_eq("on_log_after", {31'b0, on_log}, 32'd1);
    step_cycle(1, 4, 2, 4, 2);
    check_eq("on_log_post_step", {31'b0, on_log}, 32'd0);

    // Freeze for 40 cycles mid-phase, then resume.
    do_reset(1);
    repeat (2) step_cycle(1, 0, 13, 13, 1);
    repeat (40) step_cycle(0, 0, 13, 13, 1);
    check_eq("freeze_hold", {28'b0, cell_type}, 32'd2);
    step_cycle(1, 0, 13, 13, 1);
    step_cycle(1, 0, 13, 13, 1);
    check_eq("resume_pre", {28'b0, cell_type}, 32'd2);
    step_cycle(1, 0, 13, 13, 1);
    check_eq("resume_step", {28'b0, cell_type}, 32'd3);

    // Reset asserted during the step cycle restores init patterns.
    do_reset(1);
    repeat (3) step_cycle(1, 0, 13, 0, 1);
    do_reset(2);
    step_cycle(1, 0, 13, 0, 1);
    check_eq("rst_restore_c0", {28'b0, cell_type}, 32'd3);
    step_cycle(1, 0, 13, 13, 1);
    check_eq("rst_restore_c13", {28'b0, cell_type}, 32'd2);

    // Randomized play: frog lingers on rows so carries and collisions occur.
    fx = 5; fy = 2;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) begin
        fx = $urandom_range(0, 15);
        fy = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(0, 16);
      end
      qc = $urandom_range(0, 16);
      qr = $urandom_range(0, 16);
      step_cycle($urandom_range(0, 7) != 0, fx, fy, qc, qr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
